// File: rtl/stage_sequencer.sv
// Instruction stage sequencer: FETCH -> DECODE -> EXEC (per-element) -> WB, with HALT.
// Latency: 4 cycles per scalar instruction, 3 + max(1, vle) cycles per vector instruction without memory waits.
// Backpressure: EXEC holds an element until mem_ready is seen when mem_op is set; HALT is left only by reset.
module stage_sequencer #(
    parameter int XLEN     = 32,
    parameter int NUM_ELEM = 16,
    parameter int ELEM_W   = 4,
    parameter int PC_STEP  = 1,
    parameter int RESET_PC = 0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_vec_op,
    input  logic              i_mem_op,
    input  logic              i_mem_ready,
    input  logic [ELEM_W:0]   i_vl,
    input  logic              i_br_taken,
    input  logic [XLEN-1:0]   i_br_target,
    input  logic              i_halt_req,
    output logic [XLEN-1:0]   o_pc,
    output logic              o_stg_fetch,
    output logic              o_stg_decode,
    output logic              o_stg_exec,
    output logic              o_stg_wb,
    output logic [ELEM_W-1:0] o_ele_index,
    output logic              o_elem_valid,
    output logic              o_ele_last,
    output logic              o_retire,
    output logic              o_halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [ELEM_W:0]   L_NUM_ELEM = (ELEM_W+1)'(NUM_ELEM);
    localparam logic [XLEN-1:0]   L_PC_STEP  = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0]   L_RESET_PC = XLEN'(RESET_PC);

    state_t            r_state;
    state_t            w_next;
    logic [XLEN-1:0]   r_pc;
    logic [ELEM_W-1:0] r_ele_index;

    logic [ELEM_W:0]   w_vle;
    logic              w_vec_empty;
    logic              w_elem_valid;
    logic              w_is_last;
    logic              w_elem_done;

    // Element bookkeeping: clamp vl to the hardware limit and qualify the active element.
    always_comb begin
        w_vle        = (i_vl > L_NUM_ELEM) ? L_NUM_ELEM : i_vl;
        w_vec_empty  = i_vec_op && (w_vle == '0);
        w_elem_valid = (r_state == S_EXEC) && !w_vec_empty;
        // vle-1 wraps when vle==0, but elem_valid masks that case out.
        w_is_last    = !i_vec_op || ({1'b0, r_ele_index} == (w_vle - 1'b1));
        w_elem_done  = w_elem_valid && (!i_mem_op || i_mem_ready);
    end

    // State register; reset lands directly in FETCH so the first fetch is the cycle reset drops.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and stage enables, decoded from the state register only.
    always_comb begin
        w_next       = r_state;
        o_stg_fetch  = 1'b0;
        o_stg_decode = 1'b0;
        o_stg_exec   = 1'b0;
        o_stg_wb     = 1'b0;
        o_retire     = 1'b0;
        o_halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_stg_fetch = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                o_stg_decode = 1'b1;
                w_next       = S_EXEC;
            end
            S_EXEC: begin
                o_stg_exec = 1'b1;
                if (w_vec_empty || (w_elem_done && w_is_last)) begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                o_stg_wb = 1'b1;
                o_retire = 1'b1;
                w_next   = i_halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                o_halted = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // PC advances or redirects in WB; element index steps on each non-final element completion.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pc        <= L_RESET_PC;
            r_ele_index <= '0;
        end else if (r_state == S_WB) begin
            r_pc        <= i_br_taken ? i_br_target : (r_pc + L_PC_STEP);
            r_ele_index <= '0;
        end else if (w_elem_done && !w_is_last) begin
            r_ele_index <= r_ele_index + ELEM_W'(1);
        end
    end

    assign o_pc         = r_pc;
    assign o_ele_index  = r_ele_index;
    assign o_elem_valid = w_elem_valid;
    assign o_ele_last   = w_elem_valid && w_is_last;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: scalar, branch, vector, memory-wait, clamp, reset and halt.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// All expected values are hand-computed constants or loop indices.
module tb_stage_sequencer;

    localparam int XLEN   = 32;
    localparam int ELEM_W = 4;

    logic              i_clock;
    logic              i_reset;
    logic              i_vec_op;
    logic              i_mem_op;
    logic              i_mem_ready;
    logic [ELEM_W:0]   i_vl;
    logic              i_br_taken;
    logic [XLEN-1:0]   i_br_target;
    logic              i_halt_req;
    logic [XLEN-1:0]   o_pc;
    logic              o_stg_fetch;
    logic              o_stg_decode;
    logic              o_stg_exec;
    logic              o_stg_wb;
    logic [ELEM_W-1:0] o_ele_index;
    logic              o_elem_valid;
    logic              o_ele_last;
    logic              o_retire;
    logic              o_halted;

    int n_chk  = 0;
    int n_pass = 0;

    stage_sequencer #(
        .XLEN(XLEN), .NUM_ELEM(16), .ELEM_W(ELEM_W), .PC_STEP(1), .RESET_PC(0)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_vec_op(i_vec_op), .i_mem_op(i_mem_op),
        .i_mem_ready(i_mem_ready), .i_vl(i_vl), .i_br_taken(i_br_taken),
        .i_br_target(i_br_target), .i_halt_req(i_halt_req), .o_pc(o_pc),
        .o_stg_fetch(o_stg_fetch), .o_stg_decode(o_stg_decode), .o_stg_exec(o_stg_exec),
        .o_stg_wb(o_stg_wb), .o_ele_index(o_ele_index), .o_elem_valid(o_elem_valid),
        .o_ele_last(o_ele_last), .o_retire(o_retire), .o_halted(o_halted)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to 1 ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Let combinational outputs settle after input changes before checking.
    task automatic settle();
        #1;
    endtask

    // Stage enables as {fetch, decode, exec, wb}.
    function automatic logic [3:0] stg();
        return {o_stg_fetch, o_stg_decode, o_stg_exec, o_stg_wb};
    endfunction

    task automatic set_op(input logic vec, input logic mem, input logic [ELEM_W:0] vl);
        i_vec_op = vec;
        i_mem_op = mem;
        i_vl     = vl;
    endtask

    initial begin
        i_reset = 1'b1; i_vec_op = 1'b0; i_mem_op = 1'b0; i_mem_ready = 1'b0;
        i_vl = '0; i_br_taken = 1'b0; i_br_target = '0; i_halt_req = 1'b0;

        // Reset state
        #2;
        chk("rst_stg", 64'(stg()), 64'b1000);
        chk("rst_pc", 64'(o_pc), 64'd0);
        chk("rst_idx", 64'(o_ele_index), 64'd0);
        chk("rst_retire", 64'(o_retire), 64'd0);
        chk("rst_halted", 64'(o_halted), 64'd0);
        tick();
        i_reset = 1'b0;
        settle();

        // Three scalar non-mem instructions: pc 0,1,2 at FETCH, retire on every 4th cycle
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sc%0d_fetch", k), 64'(stg()), 64'b1000);
            chk($sformatf("sc%0d_pc", k), 64'(o_pc), 64'(k));
            chk($sformatf("sc%0d_ret_f", k), 64'(o_retire), 64'd0);
            tick(); settle();
            chk($sformatf("sc%0d_dec", k), 64'(stg()), 64'b0100);
            tick(); settle();
            chk($sformatf("sc%0d_exec", k), 64'(stg()), 64'b0010);
            chk($sformatf("sc%0d_ev", k), 64'(o_elem_valid), 64'd1);
            chk($sformatf("sc%0d_last", k), 64'(o_ele_last), 64'd1);
            tick(); settle();
            chk($sformatf("sc%0d_wb", k), 64'(stg()), 64'b0001);
            chk($sformatf("sc%0d_retire", k), 64'(o_retire), 64'd1);
            tick(); settle();
        end
        chk("sc_pc3", 64'(o_pc), 64'd3);
        chk("sc_fetch3", 64'(stg()), 64'b1000);

        // Branch asserted outside WB only: no redirect
        i_br_taken = 1'b1; i_br_target = 32'h80;
        tick(); tick(); settle();
        chk("brx_exec_pc", 64'(o_pc), 64'd3);
        tick();
        i_br_taken = 1'b0;
        settle();
        chk("brx_wb", 64'(stg()), 64'b0001);
        tick(); settle();
        chk("brx_pc", 64'(o_pc), 64'd4);

        // Branch taken in WB: redirect to 0x40
        tick(); tick(); tick();
        i_br_taken = 1'b1; i_br_target = 32'h40;
        settle();
        chk("br_wb", 64'(stg()), 64'b0001);
        tick();
        i_br_taken = 1'b0; i_br_target = '0;
        settle();
        chk("br_fetch", 64'(stg()), 64'b1000);
        chk("br_pc", 64'(o_pc), 64'h40);

        // Vector, no memory, vl=4: 7-cycle instruction, index 0..3
        set_op(1'b1, 1'b0, 5'd4);
        tick(); settle();
        chk("v4_dec", 64'(stg()), 64'b0100);
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            chk($sformatf("v4_e%0d_stg", i), 64'(stg()), 64'b0010);
            chk($sformatf("v4_e%0d_idx", i), 64'(o_ele_index), 64'(i));
            chk($sformatf("v4_e%0d_last", i), 64'(o_ele_last), 64'(i == 3));
        end
        tick(); settle();
        chk("v4_wb", 64'(stg()), 64'b0001);
        tick(); settle();
        chk("v4_pc", 64'(o_pc), 64'h41);
        chk("v4_idx0", 64'(o_ele_index), 64'd0);

        // Vector with memory, vl=2, mem_ready per EXEC cycle 0,1,0,0,1; mem_ready in DECODE ignored
        begin
            logic [4:0] rdy_seq;
            logic [4:0] idx_seq;
            rdy_seq = 5'b10010;  // bit c = mem_ready in EXEC cycle c
            idx_seq = 5'b11100;  // bit c = expected index in EXEC cycle c
            set_op(1'b1, 1'b1, 5'd2);
            i_mem_ready = 1'b1;
            tick(); settle();
            chk("vm_dec", 64'(stg()), 64'b0100);
            for (int c = 0; c < 5; c++) begin
                tick();
                i_mem_ready = rdy_seq[c];
                settle();
                chk($sformatf("vm_c%0d_stg", c), 64'(stg()), 64'b0010);
                chk($sformatf("vm_c%0d_idx", c), 64'(o_ele_index), 64'(idx_seq[c]));
            end
            tick();
            i_mem_ready = 1'b0;
            settle();
            chk("vm_wb", 64'(stg()), 64'b0001);
            tick(); settle();
            chk("vm_pc", 64'(o_pc), 64'h42);
        end

        // vl=0: one EXEC cycle, no element, no memory wait even with mem_ready low
        set_op(1'b1, 1'b1, 5'd0);
        tick(); tick(); settle();
        chk("v0_exec", 64'(stg()), 64'b0010);
        chk("v0_ev", 64'(o_elem_valid), 64'd0);
        chk("v0_last", 64'(o_ele_last), 64'd0);
        tick(); settle();
        chk("v0_wb", 64'(stg()), 64'b0001);
        tick(); settle();
        chk("v0_pc", 64'(o_pc), 64'h43);

        // vl=20 clamps to 16 elements, last index 15
        set_op(1'b1, 1'b0, 5'd20);
        tick();
        for (int i = 0; i < 16; i++) begin
            tick(); settle();
            chk($sformatf("v20_e%0d_stg", i), 64'(stg()), 64'b0010);
            chk($sformatf("v20_e%0d_idx", i), 64'(o_ele_index), 64'(i));
            chk($sformatf("v20_e%0d_last", i), 64'(o_ele_last), 64'(i == 15));
        end
        tick(); settle();
        chk("v20_wb", 64'(stg()), 64'b0001);
        tick(); settle();
        chk("v20_pc", 64'(o_pc), 64'h44);

        // Scalar memory op: EXEC held until mem_ready
        set_op(1'b0, 1'b1, 5'd0);
        tick(); tick(); settle();
        chk("sm_e0", 64'(stg()), 64'b0010);
        tick(); settle();
        chk("sm_e1", 64'(stg()), 64'b0010);
        i_mem_ready = 1'b1;
        tick();
        i_mem_ready = 1'b0;
        settle();
        chk("sm_wb", 64'(stg()), 64'b0001);
        tick(); settle();
        chk("sm_pc", 64'(o_pc), 64'h45);

        // Reset mid-EXEC at index 5 takes effect in the same cycle
        set_op(1'b1, 1'b0, 5'd16);
        tick();
        for (int i = 0; i < 6; i++) tick();
        settle();
        chk("mr_idx5", 64'(o_ele_index), 64'd5);
        i_reset = 1'b1;
        settle();
        chk("mr_stg", 64'(stg()), 64'b1000);
        chk("mr_pc", 64'(o_pc), 64'd0);
        chk("mr_idx", 64'(o_ele_index), 64'd0);
        chk("mr_retire", 64'(o_retire), 64'd0);
        tick();
        i_reset = 1'b0;
        set_op(1'b0, 1'b0, 5'd0);
        settle();
        chk("mr_fetch_pc", 64'(o_pc), 64'd0);

        // halt_req in WB: HALT with all enables low until reset
        tick(); tick(); tick();
        i_halt_req = 1'b1;
        settle();
        chk("h_wb", 64'(stg()), 64'b0001);
        tick();
        i_halt_req = 1'b0;
        settle();
        chk("h_stg", 64'(stg()), 64'b0000);
        chk("h_halted", 64'(o_halted), 64'd1);
        chk("h_pc", 64'(o_pc), 64'd1);
        tick(); tick(); tick(); settle();
        chk("h_hold_stg", 64'(stg()), 64'b0000);
        chk("h_hold_halted", 64'(o_halted), 64'd1);
        chk("h_hold_retire", 64'(o_retire), 64'd0);
        i_reset = 1'b1;
        settle();
        chk("h_rst_stg", 64'(stg()), 64'b1000);
        chk("h_rst_halted", 64'(o_halted), 64'd0);
        chk("h_rst_pc", 64'(o_pc), 64'd0);
        tick();
        i_reset = 1'b0;
        tick(); settle();
        chk("h_rst_dec", 64'(stg()), 64'b0100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL: parameter XLEN, default 32, PC and branch-target width.
REQ-002 SHALL: parameter NUM_ELEM, default 16, maximum vector elements per instruction.
REQ-003 SHALL: parameter ELEM_W, default 4, element index width; NUM_ELEM <= 2**ELEM_W.
REQ-004 SHALL: parameter PC_STEP, default 1, PC increment per sequential instruction.
REQ-005 SHALL: parameter RESET_PC, default 0, PC value after reset.
REQ-006 SHALL: clock  input  1  single clock; all state updates on the rising edge.
REQ-007 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL: vec_op  input  1  current instruction iterates over vector elements.
REQ-009 SHALL: mem_op  input  1  current instruction/element needs data-memory completion.
REQ-010 SHALL: mem_ready  input  1  memory completion for the current access.
REQ-011 SHALL: vl  input  ELEM_W+1  active vector length.
REQ-012 SHALL: br_taken  input  1  branch resolved taken; sampled in WB.
REQ-013 SHALL: br_target  input  XLEN  redirect address; sampled in WB.
REQ-014 SHALL: halt_req  input  1  stop after the current instruction; sampled in WB.
REQ-015 SHALL: pc  output  XLEN  address of the instruction being fetched/executed.
REQ-016 SHALL: stg_fetch, stg_decode, stg_exec, stg_wb  output  1 each  one-hot stage enables.
REQ-017 SHALL: ele_index  output  ELEM_W  current element index.
REQ-018 SHALL: elem_valid  output  1  an element is active this EXEC cycle.
REQ-019 SHALL: ele_last  output  1  the current element is the final one.
REQ-020 SHALL: retire  output  1  one-cycle pulse in WB.
REQ-021 SHALL: halted  output  1  sequencer stopped.

Function
REQ-022 SHALL: states FETCH, DECODE, EXEC, WB, HALT; stage enables decoded from the state register only; all enables low in HALT.
REQ-023 SHALL: FETCH->DECODE->EXEC unconditionally, one cycle each.
REQ-024 SHALL: scalar, mem_op=0: EXEC lasts 1 cycle; instruction latency 4 cycles.
REQ-025 SHALL: scalar, mem_op=1: EXEC held until mem_ready=1 is sampled, then WB.
REQ-026 SHALL: vec_op=1: effective length vle = min(vl, NUM_ELEM); ele_index starts at 0 on EXEC entry.
REQ-027 SHALL: each element completes on a cycle where mem_op=0 or mem_ready=1; index increments on completion; EXEC exits after element vle-1 completes.
REQ-028 SHALL: elem_valid=1 in EXEC for vec_op with vle>0, and for scalar ops; ele_last=1 when elem_valid and (scalar, or ele_index==vle-1).
REQ-029 SHALL: vle=0: EXEC lasts one cycle, elem_valid=0, no memory wait.
REQ-030 SHALL: WB: pc <= br_taken ? br_target : pc+PC_STEP (modulo 2**XLEN); retire=1; ele_index <= 0.
REQ-031 SHALL: WB with halt_req=1 -> HALT after the pc update; HALT exited only by reset.
REQ-032 SHALL: vec_op, mem_op, vl held stable by the decoder from DECODE through EXEC; changes mid-EXEC are undefined.
REQ-033 SHALL: mem_ready outside EXEC ignored.

Reset
REQ-034 SHALL: reset asserted at any time, including mid-EXEC or in HALT, immediately forces state FETCH, pc=RESET_PC, ele_index=0, retire=0, halted=0, stg_fetch=1, other enables 0.
REQ-035 SHALL: first FETCH occurs in the cycle reset is deasserted; no partial instruction retires.

Verification
REQ-036 SHALL: reset, three scalar non-mem ops -> pc 0,1,2,3 at successive FETCH; retire every 4th cycle; enables strictly one-hot.
REQ-037 SHALL: br_taken=1, br_target=0x40 in WB -> next FETCH with pc=0x40; br_taken=1 outside WB has no effect.
REQ-038 SHALL: vec_op=1, mem_op=0, vl=4 -> ele_index 0,1,2,3 on four consecutive EXEC cycles, ele_last on index 3, latency 7 cycles.
REQ-039 SHALL: vec_op=1, mem_op=1, vl=2, mem_ready per EXEC cycle 0,1,0,0,1 -> index 0 for 2 cycles, index 1 for 3 cycles, then WB.
REQ-040 SHALL: vl=0 -> single EXEC cycle, elem_valid=0; vl=20 with NUM_ELEM=16 -> exactly 16 elements, last index 15.
REQ-041 SHALL: reset pulse during EXEC at index 5 -> same cycle state FETCH, pc=0, ele_index=0; halt_req=1 in WB -> halted=1, all enables 0 until reset.
